lcd_grey_scaler: RTL

- Frame-rate-control (FRC) grey scaler that sits directly upstream of the LCD pixel formatter.
- Accepts 12-bit RGB444 pixels (or 4-bit mono intensity) from the pixel unpack stage.
- Per colour component, emits one bit per frame (greypixel[2:0] = {blue, green, red}), modulated over 16 frames so the time-averaged duty approximates the 4-bit intensity.
- Handshakes with the formatter through valid/stall and back-pressures the unpack stage through pix_ready.

---
 rtl/lcd_grey_scaler.sv | 81 ++++++++
 1 files changed

// File: rtl/lcd_grey_scaler.sv
// lcd_grey_scaler: FRC grey scaler, one modulated bit per colour per frame over 16 frames.
// Define LCD_GREY_DITHER_EN to add the 4x4 spatial term (ordered spatio-temporal dither).
module lcd_grey_scaler #(
  parameter int FRAME_BITS = 4,
  parameter int LINE_BITS  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           pixin,
  input  logic                  pixvalid,
  output logic                  pix_ready,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  mono,
  output logic [2:0]            greypixel,
  output logic                  valid,
  input  logic                  stall,
  output logic [FRAME_BITS-1:0] frame_cnt
);
  logic                  valid_q, valid_d;
  logic [2:0]            grey_q, grey_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d, f_eff;
  logic [3:0]            idx, t;
  logic                  accept;

  function automatic logic frc_bit(input logic [3:0] i, input logic [3:0] thr);
    return (i == 4'hF) || (i > thr);
  endfunction

  assign pix_ready = !valid_q || !stall;
  assign accept    = pixvalid && pix_ready;
  assign f_eff     = frame_start ? frame_q + 1'b1 : frame_q;
  assign t         = {idx[0], idx[1], idx[2], idx[3]};

`ifdef LCD_GREY_DITHER_EN
  logic [1:0]           x_q, x_d, x_eff;
  logic [LINE_BITS-1:0] y_q, y_d, y_eff;
  // Same-cycle pulses already apply to the pixel accepted in that cycle.
  always_comb begin
    x_eff = (frame_start || line_start) ? 2'd0 : x_q;
    y_eff = frame_start ? '0 : line_start ? y_q + 1'b1 : y_q;
    x_d   = accept ? x_eff + 2'd1 : x_eff;
    y_d   = y_eff;
    idx   = f_eff[3:0] + {y_eff[1:0], x_eff};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
`else
  logic unused_line;
  assign unused_line = line_start;
  assign idx         = f_eff[3:0];
`endif

  always_comb begin
    frame_d = f_eff;
    valid_d = accept ? 1'b1 : (stall ? valid_q : 1'b0);
    grey_d  = accept ? {!mono && frc_bit(pixin[11:8], t), !mono && frc_bit(pixin[7:4], t),
                        frc_bit(pixin[3:0], t)} : grey_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      grey_q  <= '0;
      frame_q <= '0;
    end else begin
      valid_q <= valid_d;
      grey_q  <= grey_d;
      frame_q <= frame_d;
    end

  assign valid     = valid_q;
  assign greypixel = grey_q;
  assign frame_cnt = frame_q;
endmodule
